// File: rtl/uram_rd_pkg.sv
// Shared types and constants for the URAM stream reader.
// Optional feature macro: URAM_RD_PERF_EN (see uram_stream_reader).
package uram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } rd_state_t;

    localparam int DEF_ADDR_WIDTH = 14;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_RD_LATENCY = 2;

    // The output buffer must absorb every in-flight read plus keep one
    // beat of slack so issue never stalls while the consumer is ready.
    function automatic bit fifo_depth_ok(input int depth, input int rd_latency);
        return depth >= rd_latency + 2;
    endfunction

endpackage

// File: rtl/uram_rd_fifo.sv
// Small show-ahead synchronous FIFO holding {last, data} beats for the
// URAM stream reader. Head word reads as zero while the FIFO is empty.
module uram_rd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    // Storage array, written at the tail pointer
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uram_stream_reader.sv
// Read-side master for the URAM buffer port B: on start, reads len words
// from base_addr and streams them out with valid/ready and last marking.
// Reads are issued against credits (in-flight + buffered < FIFO_DEPTH) so
// consumer backpressure never drops returning data.
// Optional macro URAM_RD_PERF_EN adds a 32-bit stall_cnt output.
module uram_stream_reader
    import uram_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addrb,
    output logic                  mem_enb,
    input  logic [DATA_WIDTH-1:0] mem_doutb,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
`ifdef URAM_RD_PERF_EN
    output logic                  m_tlast,
    output logic [31:0]           stall_cnt
`else
    output logic                  m_tlast
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_WIDTH:0] LEFT_ONE = (ADDR_WIDTH + 1)'(1);

    generate
        if (!fifo_depth_ok(FIFO_DEPTH, RD_LATENCY)) begin : g_depth_check
            $error("uram_stream_reader: FIFO_DEPTH must be >= RD_LATENCY+2");
        end
    endgenerate

    rd_state_t             state_reg;
    rd_state_t             state_next;
    logic [ADDR_WIDTH-1:0] rd_addr_reg;
    logic [ADDR_WIDTH:0]   issue_left_reg;
    logic [INF_W-1:0]      inflight_reg;
    logic                  issue_last;
    logic                  credit_ok;
    logic                  accept;
    logic                  beat_hs;
    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_WIDTH:0]   fifo_dout;

    assign accept     = (state_reg == IDLE) && start;
    assign credit_ok  = ((int'(inflight_reg) + int'(fifo_count)) < FIFO_DEPTH) && !fifo_full;
    assign issue_last = mem_enb && (issue_left_reg == LEFT_ONE);
    assign beat_hs    = m_tvalid && m_tready;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = (len == '0) ? FINISH : ISSUE;
            ISSUE:   if (issue_last) state_next = DRAIN;
            DRAIN:   if (beat_hs && m_tlast) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: status and credit-gated read issue
    always_comb begin
        busy      = (state_reg == ISSUE) || (state_reg == DRAIN);
        done      = (state_reg == FINISH);
        mem_enb   = (state_reg == ISSUE) && (issue_left_reg != '0) && credit_ok;
        mem_addrb = rd_addr_reg;
    end

    // Read address and remaining-issue count; address wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_reg    <= '0;
            issue_left_reg <= '0;
        end else if (accept) begin
            rd_addr_reg    <= base_addr;
            issue_left_reg <= len;
        end else if (mem_enb) begin
            rd_addr_reg    <= rd_addr_reg + 1'b1;
            issue_left_reg <= issue_left_reg - 1'b1;
        end
    end

    // Latency pipe: valid and last bits shadow each read until its data lands
    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_lat
            logic vld_reg;
            logic last_reg;
            if (gi == 0) begin : g_first
                // First stage captures the read being issued this cycle
                always_ff @(posedge clk) begin
                    if (rst) begin
                        vld_reg  <= 1'b0;
                        last_reg <= 1'b0;
                    end else begin
                        vld_reg  <= mem_enb;
                        last_reg <= issue_last;
                    end
                end
            end else begin : g_next
                // Later stages shift the tags forward one cycle
                always_ff @(posedge clk) begin
                    if (rst) begin
                        vld_reg  <= 1'b0;
                        last_reg <= 1'b0;
                    end else begin
                        vld_reg  <= g_lat[gi-1].vld_reg;
                        last_reg <= g_lat[gi-1].last_reg;
                    end
                end
            end
        end
    endgenerate

    assign fifo_push = g_lat[RD_LATENCY-1].vld_reg;

    // Reads issued but not yet written into the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= '0;
        end else if (mem_enb && !fifo_push) begin
            inflight_reg <= inflight_reg + 1'b1;
        end else if (fifo_push && !mem_enb) begin
            inflight_reg <= inflight_reg - 1'b1;
        end
    end

    uram_rd_fifo #(
        .WIDTH(DATA_WIDTH + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .srst (rst),
        .push (fifo_push),
        .din  ({g_lat[RD_LATENCY-1].last_reg, mem_doutb}),
        .pop  (beat_hs),
        .dout (fifo_dout),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign m_tvalid = !fifo_empty;
    assign m_tdata  = fifo_dout[DATA_WIDTH-1:0];
    assign m_tlast  = fifo_dout[DATA_WIDTH];

`ifdef URAM_RD_PERF_EN
    // Saturating count of stalled output cycles, cleared per command
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            stall_cnt <= '0;
        end else if (m_tvalid && !m_tready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uram_stream_reader.sv
// Directed self-checking bench for uram_stream_reader with a latency-2
// URAM read model whose word content is a function of its address.
// Honours URAM_RD_PERF_EN when defined.
module tb_uram_stream_reader;

    localparam int AW = 14;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addrb;
    logic          mem_enb;
    logic [DW-1:0] mem_doutb;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
`ifdef URAM_RD_PERF_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   stall_at_done;
    logic [31:0]   stall_hold;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Per-command observations
    logic [AW-1:0] enb_q[$];
    logic [DW-1:0] beat_d[$];
    logic          beat_l[$];
    int first_enb, first_beat, last_beat, done_cyc;
    int stalls, stable_err, credit_err, tvalid_seen;
    logic busy_at_done;
    bit finished;
    int nb, guard, idle_activity;

    uram_stream_reader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .mem_addrb(mem_addrb),
        .mem_enb  (mem_enb),
        .mem_doutb(mem_doutb),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
`ifdef URAM_RD_PERF_EN
        .m_tlast  (m_tlast),
        .stall_cnt(stall_cnt)
`else
        .m_tlast  (m_tlast)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {16'hCAFE, 2'b00, a, 16'h5A5A, 2'b00, ~a};
    endfunction

    // URAM model: data for the address presented two cycles earlier
    logic [AW-1:0] addr_d1, addr_d2;
    always @(posedge clk) begin
        addr_d1 <= mem_addrb;
        addr_d2 <= addr_d1;
    end
    assign mem_doutb = mem_word(addr_d2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and observe until done (bounded).
    task automatic run_cmd(input string name, input logic [AW-1:0] base, input logic [AW:0] n,
                           input int ready_pct, input int restart_at);
        int cyc, issued, popped;
        bit prev_stall;
        logic [DW-1:0] prev_data;
        logic prev_last;
        enb_q.delete(); beat_d.delete(); beat_l.delete();
        first_enb = -1; first_beat = -1; last_beat = -1; done_cyc = -1;
        stalls = 0; stable_err = 0; credit_err = 0; tvalid_seen = 0;
        busy_at_done = 1'b1; finished = 0;
        issued = 0; popped = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
        start = 1'b1; base_addr = base; len = n; m_tready = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (!finished && cyc < 400) begin
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last))
                stable_err++;
            if (mem_enb === 1'b1) begin
                if (issued - popped >= 4) credit_err++;
                enb_q.push_back(mem_addrb);
                if (first_enb < 0) first_enb = cyc;
            end
            m_tready = ($urandom_range(0, 99) < ready_pct) ? 1'b1 : 1'b0;
            if (m_tvalid === 1'b1) tvalid_seen++;
            if (m_tvalid === 1'b1 && m_tready) begin
                beat_d.push_back(m_tdata);
                beat_l.push_back(m_tlast);
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
                popped++;
            end
            if (m_tvalid === 1'b1 && !m_tready) stalls++;
            if (mem_enb === 1'b1) issued++;
            prev_stall = (m_tvalid === 1'b1) && !m_tready;
            prev_data = m_tdata;
            prev_last = m_tlast;
            if (done === 1'b1) begin
                done_cyc = cyc;
                busy_at_done = busy;
                finished = 1;
`ifdef URAM_RD_PERF_EN
                stall_at_done = stall_cnt;
`endif
            end
            start = (cyc == restart_at);
            if (start) begin
                base_addr = 14'h0100;
                len = 15'd8;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        check({name, " finished"}, finished, 1);
        $display("cmd %s base=%h len=%0d: issued=%0d beats=%0d done_cyc=%0d stalls=%0d",
                 name, base, n, enb_q.size(), beat_d.size(), done_cyc, stalls);
    endtask

    // Address order, data, last flags for the command just run.
    task automatic check_stream(input string name, input logic [AW-1:0] base, input int n);
        logic [AW-1:0] a;
        check({name, " enb_count"}, enb_q.size(), n);
        check({name, " beat_count"}, beat_d.size(), n);
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            if (i < enb_q.size())
                check($sformatf("%s addr[%0d]", name, i), enb_q[i], a);
            if (i < beat_d.size()) begin
                check($sformatf("%s data[%0d]", name, i), beat_d[i], mem_word(a));
                check($sformatf("%s last[%0d]", name, i), beat_l[i], (i == n - 1));
            end
        end
        check({name, " busy_at_done"}, busy_at_done, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " busy"}, busy, 0);
        check({name, " done"}, done, 0);
        check({name, " mem_enb"}, mem_enb, 0);
        check({name, " mem_addrb"}, mem_addrb, 0);
        check({name, " m_tvalid"}, m_tvalid, 0);
        check({name, " m_tlast"}, m_tlast, 0);
        check({name, " m_tdata"}, m_tdata, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_tready = 1'b0;
        step(); step(); step();
        check_reset_outputs("reset");
`ifdef URAM_RD_PERF_EN
        check("reset stall_cnt", stall_cnt, 0);
`endif
        rst = 1'b0;
        step();

        // Straight 8-word read, consumer always ready
        run_cmd("t1", 14'h0010, 15'd8, 100, -1);
        check_stream("t1", 14'h0010, 8);
        check("t1 first_enb", first_enb, 1);
        check("t1 enb_span", last_beat - first_beat, 7);
        check("t1 first_beat_lat", first_beat - first_enb, 3);
        check("t1 done_lat", done_cyc - last_beat, 1);
`ifdef URAM_RD_PERF_EN
        check("t1 stall_cnt", stall_at_done, 0);
`endif

        // Address wrap at top of the buffer
        run_cmd("t2", 14'h3FFE, 15'd4, 100, -1);
        check_stream("t2", 14'h3FFE, 4);

        // Random backpressure
        run_cmd("t3", 14'h0200, 15'd16, 50, -1);
        check_stream("t3", 14'h0200, 16);
        check("t3 stable_during_stall", stable_err, 0);
        check("t3 credit_violations", credit_err, 0);
        check("t3 done_lat", done_cyc - last_beat, 1);
`ifdef URAM_RD_PERF_EN
        check("t3 stall_cnt", stall_at_done, stalls);
        stall_hold = stall_cnt;
        step(); step();
        check("t3 stall_cnt_hold", stall_cnt, stall_hold);
`endif

        // Zero-length command
        run_cmd("t4", 14'h0055, 15'd0, 100, -1);
        check("t4 enb_count", enb_q.size(), 0);
        check("t4 tvalid_seen", tvalid_seen, 0);
        check("t4 done_cyc", done_cyc, 1);
        check("t4 busy_at_done", busy_at_done, 0);

        // Second start while busy is ignored
        run_cmd("t5", 14'h0040, 15'd8, 100, 2);
        check_stream("t5", 14'h0040, 8);
        step(); step();
        check("t5 idle_after", busy, 0);

        // Reset after three beats of an 8-word command
        start = 1'b1; base_addr = 14'h0080; len = 15'd8; m_tready = 1'b1;
        step();
        start = 1'b0;
        nb = 0; guard = 0;
        while (nb < 3 && guard < 50) begin
            if (m_tvalid === 1'b1 && m_tready) nb++;
            if (nb == 3) rst = 1'b1;
            step();
            guard++;
        end
        check("t6 beats_before_rst", nb, 3);
        check_reset_outputs("t6 rst");
        rst = 1'b0;
        idle_activity = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_tvalid !== 1'b0 || done !== 1'b0 || mem_enb !== 1'b0 || busy !== 1'b0)
                idle_activity++;
            step();
        end
        check("t6 quiet_after_rst", idle_activity, 0);
        $display("cmd t6 reset after %0d beats, activity after reset=%0d", nb, idle_activity);

        run_cmd("t7", 14'h0300, 15'd2, 100, -1);
        check_stream("t7", 14'h0300, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
